pipe_stage_skid: RTL and testbench

- Parametrised, handshaked successor to the fixed inter-stage registers (ID/EX-style) of the pipelined core.
- Carries one generic control vector and one generic data vector between two stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so stalls propagate without combinational ready paths.
- Supports a synchronous flush (bubble insert) and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_skid_pkg.sv | 48 ++++
 rtl/pipe_stage_skid_if.sv | 24 ++
 rtl/pipe_entry_reg.sv | 57 +++++
 rtl/pipe_stage_skid.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the handshaked inter-stage register: state encoding,
// control-vector field layout and small helpers.
package pipe_stage_skid_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_ONE   = 2'd1,
      PS_FULL  = 2'd2
   } ps_state_e;

   // Entry slot indices inside the stage.
   localparam int ENT_MAIN = 0;
   localparam int ENT_SKID = 1;
   localparam int ENT_NUM  = 2;

   // Control-vector field layout used by the core when packing/unpacking
   // in_ctrl (write enables sit in the low bits so CTRL_RST=0 kills them).
   localparam int CTRL_REG_WRITE   = 0;
   localparam int CTRL_MEM_WRITE   = 1;
   localparam int CTRL_MEM_READ    = 2;
   localparam int CTRL_MEM_TO_REG  = 3;
   localparam int CTRL_ALU_SRC     = 4;
   localparam int CTRL_REG_DST     = 5;
   localparam int CTRL_BRANCH      = 6;
   localparam int CTRL_JUMP        = 7;
   localparam int CTRL_ALU_OP_LSB  = 8;
   localparam int CTRL_ALU_OP_W    = 4;
   localparam int CTRL_FWD_SEL_LSB = 12;
   localparam int CTRL_FWD_SEL_W   = 4;
   localparam int CTRL_USED_W      = CTRL_FWD_SEL_LSB + CTRL_FWD_SEL_W;

   function automatic logic [1:0] ps_occupancy(input ps_state_e s);
      case (s)
         PS_ONE:  return 2'd1;
         PS_FULL: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic ps_can_accept(input ps_state_e s);
      return (s != PS_FULL);
   endfunction

   function automatic logic ps_has_head(input ps_state_e s);
      return (s != PS_EMPTY);
   endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one control and one data vector.
interface pipe_stage_skid_if #(
   parameter int CTRL_W = 16,
   parameter int DATA_W = 64
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (
      output valid,
      output ctrl,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  ctrl,
      input  data,
      output ready
   );
endinterface

// File: rtl/pipe_entry_reg.sv
// One {ctrl,data} holding register with load, synchronous clear and async reset.
// Clear beats load; data reset/clear is optional to save fanout.
module pipe_entry_reg #(
   parameter int                CTRL_W     = 16,
   parameter int                DATA_W     = 64,
   parameter logic [CTRL_W-1:0] CTRL_RST   = '0,
   parameter bit                CLEAR_DATA = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic [DATA_W-1:0] data_d,
   output logic [CTRL_W-1:0] ctrl_q,
   output logic [DATA_W-1:0] data_q
);

   logic [CTRL_W-1:0] ctrl_reg;
   logic [DATA_W-1:0] data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_reg <= CTRL_RST;
      end else if (clear) begin
         ctrl_reg <= CTRL_RST;
      end else if (load) begin
         ctrl_reg <= ctrl_d;
      end
   end

   generate
      if (CLEAR_DATA) begin : g_data_clr
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               data_reg <= '0;
            end else if (clear) begin
               data_reg <= '0;
            end else if (load) begin
               data_reg <= data_d;
            end
         end
      end else begin : g_data_hold
         // No reset on the wide data path; a flushed slot keeps stale data
         // but its ctrl is already the bubble value.
         always_ff @(posedge clk) begin
            if (load && !clear) begin
               data_reg <= data_d;
            end
         end
      end
   endgenerate

   assign ctrl_q = ctrl_reg;
   assign data_q = data_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Handshaked inter-stage register with a 2-entry skid buffer, flush and a
// saturating stall counter. in_ready depends only on registered state.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int                DATA_W     = 64,
   parameter int                CTRL_W     = 16,
   parameter logic [CTRL_W-1:0] CTRL_RST   = '0,
   parameter bit                CLEAR_DATA = 1'b1,
   parameter int                CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   pipe_stage_skid_if.slave    in_if,
   pipe_stage_skid_if.master   out_if,
   output logic [1:0]          occupancy,
   input  logic                cnt_clr,
   output logic [CNT_W-1:0]    stall_cnt
);

   ps_state_e state_reg, state_next;

   logic in_ready;
   logic out_valid;
   logic in_fire;
   logic out_fire;

   logic               main_load;
   logic               skid_load;
   logic               main_from_skid;
   logic [ENT_NUM-1:0] ent_load;

   logic [CTRL_W-1:0] ent_ctrl_d [ENT_NUM];
   logic [DATA_W-1:0] ent_data_d [ENT_NUM];
   logic [CTRL_W-1:0] ent_ctrl_q [ENT_NUM];
   logic [DATA_W-1:0] ent_data_q [ENT_NUM];

   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

   assign in_ready  = ps_can_accept(state_reg);
   assign out_valid = ps_has_head(state_reg);
   assign in_fire   = in_if.valid & in_ready;
   assign out_fire  = out_valid & out_if.ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= PS_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next state and slot load strobes
   always_comb begin
      state_next     = state_reg;
      main_load      = 1'b0;
      skid_load      = 1'b0;
      main_from_skid = 1'b0;

      case (state_reg)
         PS_EMPTY: begin
            if (in_fire) begin
               state_next = PS_ONE;
               main_load  = 1'b1;
            end
         end
         PS_ONE: begin
            case ({in_fire, out_fire})
               2'b10: begin
                  state_next = PS_FULL;
                  skid_load  = 1'b1;
               end
               2'b01: begin
                  state_next = PS_EMPTY;
               end
               2'b11: begin
                  main_load = 1'b1;
               end
               default: begin
                  state_next = PS_ONE;
               end
            endcase
         end
         PS_FULL: begin
            // in_ready is low here, so only the drain path can move.
            if (out_fire) begin
               state_next     = PS_ONE;
               main_load      = 1'b1;
               main_from_skid = 1'b1;
            end
         end
         default: begin
            state_next = PS_EMPTY;
         end
      endcase

      if (flush) begin
         state_next     = PS_EMPTY;
         main_load      = 1'b0;
         skid_load      = 1'b0;
         main_from_skid = 1'b0;
      end
   end

   assign ent_load[ENT_MAIN] = main_load;
   assign ent_load[ENT_SKID] = skid_load;

   assign ent_ctrl_d[ENT_MAIN] = main_from_skid ? ent_ctrl_q[ENT_SKID] : in_if.ctrl;
   assign ent_data_d[ENT_MAIN] = main_from_skid ? ent_data_q[ENT_SKID] : in_if.data;
   assign ent_ctrl_d[ENT_SKID] = in_if.ctrl;
   assign ent_data_d[ENT_SKID] = in_if.data;

   genvar gi;
   generate
      for (gi = 0; gi < ENT_NUM; gi++) begin : g_entry
         pipe_entry_reg #(
            .CTRL_W     (CTRL_W),
            .DATA_W     (DATA_W),
            .CTRL_RST   (CTRL_RST),
            .CLEAR_DATA (CLEAR_DATA)
         ) u_entry (
            .clk    (clk),
            .rst    (rst),
            .load   (ent_load[gi]),
            .clear  (flush),
            .ctrl_d (ent_ctrl_d[gi]),
            .data_d (ent_data_d[gi]),
            .ctrl_q (ent_ctrl_q[gi]),
            .data_q (ent_data_q[gi])
         );
      end
   endgenerate

   // Stall counter: clear wins, saturates at all-ones, unaffected by flush.
   always_comb begin
      stall_cnt_next = stall_cnt_reg;
      if (cnt_clr) begin
         stall_cnt_next = '0;
      end else if (out_valid && !out_if.ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_next = stall_cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_reg <= '0;
      end else begin
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   assign in_if.ready  = in_ready;
   assign out_if.valid = out_valid;
   // A bubble must never leak write enables, so mask on the registered state.
   assign out_if.ctrl  = out_valid ? ent_ctrl_q[ENT_MAIN] : CTRL_RST;
   assign out_if.data  = ent_data_q[ENT_MAIN];
   assign occupancy    = ps_occupancy(state_reg);
   assign stall_cnt    = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomised bench for pipe_stage_skid against a queue-based FIFO model.
module tb_pipe_stage_skid;

   localparam int CW = 16;
   localparam int DW = 64;
   localparam int NW = 4;
   localparam int VW = 1 + 2 + 1 + NW + CW + DW;

   typedef struct packed {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          cnt_clr;
   logic [1:0]    occupancy;
   logic [NW-1:0] stall_cnt;

   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) in_bus ();
   pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) out_bus ();

   pipe_stage_skid #(
      .DATA_W     (DW),
      .CTRL_W     (CW),
      .CTRL_RST   ({CW{1'b0}}),
      .CLEAR_DATA (1'b1),
      .CNT_W      (NW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_if     (in_bus),
      .out_if    (out_bus),
      .occupancy (occupancy),
      .cnt_clr   (cnt_clr),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a FIFO of at most two entries plus a saturating counter.
   ent_t          q[$];
   logic [NW-1:0] cnt;

   logic [VW-1:0] dut_vec;
   assign dut_vec = {out_bus.valid, occupancy, in_bus.ready, stall_cnt, out_bus.ctrl,
                     out_bus.valid ? out_bus.data : {DW{1'b0}}};

   function automatic logic [VW-1:0] model_vec();
      logic          v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      v = (q.size() != 0);
      c = v ? q[0].ctrl : {CW{1'b0}};
      d = v ? q[0].data : {DW{1'b0}};
      return {v, 2'(q.size()), (q.size() < 2), cnt, c, d};
   endfunction

   function automatic ent_t rand_ent();
      ent_t e;
      e.ctrl = CW'($urandom);
      e.data = {$urandom, $urandom};
      return e;
   endfunction

   // Advance one clock; the model consumes the inputs seen at the edge.
   task automatic tick();
      ent_t e;
      bit   inf, outf;
      @(posedge clk);
      if (rst) begin
         q.delete();
         cnt = '0;
      end else begin
         inf  = in_bus.valid && (q.size() < 2);
         outf = out_bus.ready && (q.size() > 0);
         if (cnt_clr) cnt = '0;
         else if (q.size() > 0 && !out_bus.ready && cnt != {NW{1'b1}}) cnt = cnt + 1'b1;
         if (flush) begin
            q.delete();
         end else begin
            if (outf) void'(q.pop_front());
            if (inf) begin
               e.ctrl = in_bus.ctrl;
               e.data = in_bus.data;
               q.push_back(e);
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      ent_t e;
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL reset_idle: dut=%h model=%h", dut_vec, model_vec());
      end
      out_bus.ready = 1'b0;
      in_bus.valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e = rand_ent();
         e.ctrl[0] = 1'b1;
         in_bus.ctrl = e.ctrl;
         in_bus.data = e.data;
         tick();
      end
      checks++;
      if (occupancy !== 2'd2 || dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL reset_fill: dut=%h model=%h", dut_vec, model_vec());
      end
      // Asynchronous reset mid-cycle while FULL.
      #2 rst = 1'b1;
      #1;
      q.delete();
      cnt = '0;
      checks++;
      if ({out_bus.valid, out_bus.ctrl, occupancy, stall_cnt, out_bus.data} !== '0) begin
         errors++;
         $display("FAIL async_reset: valid=%b ctrl=%h occ=%0d cnt=%0d data=%h want all 0",
                  out_bus.valid, out_bus.ctrl, occupancy, stall_cnt, out_bus.data);
      end
      in_bus.valid = 1'b0;
      tick();
      rst = 1'b0;
      checks++;
      if (in_bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: in_ready=%b want 1", in_bus.ready);
      end
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL post_reset: dut=%h model=%h", dut_vec, model_vec());
      end
   endtask

   task automatic test_streaming();
      logic [DW-1:0] seen[$];
      out_bus.ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_bus.valid = (i < 4);
         in_bus.ctrl  = CW'(i + 1);
         in_bus.data  = DW'(i + 1);
         tick();
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL stream_cycle%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
         if (i < 4) begin
            checks++;
            if (occupancy !== 2'd1) begin
               errors++;
               $display("FAIL stream_occ%0d: got %0d want 1", i, occupancy);
            end
         end
         if (out_bus.valid && out_bus.ready) seen.push_back(out_bus.data);
      end
      checks++;
      if (seen.size() != 4 || seen[0] !== 1 || seen[1] !== 2 || seen[2] !== 3 || seen[3] !== 4) begin
         errors++;
         $display("FAIL stream_order: got %p want 1,2,3,4", seen);
      end
   endtask

   task automatic test_backpressure();
      ent_t          src[3];
      logic [DW-1:0] seen[$];
      int            idx = 0;
      bit            fire_in;
      for (int i = 0; i < 3; i++) src[i] = rand_ent();
      for (int c = 0; c < 10; c++) begin
         out_bus.ready = (c >= 4);
         in_bus.valid  = (idx < 3);
         if (idx < 3) begin
            in_bus.ctrl = src[idx].ctrl;
            in_bus.data = src[idx].data;
         end
         fire_in = in_bus.valid && in_bus.ready;
         if (out_bus.valid && out_bus.ready) seen.push_back(out_bus.data);
         tick();
         if (fire_in) idx++;
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL bp_cycle%0d: dut=%h model=%h", c, dut_vec, model_vec());
         end
         if (c == 3) begin
            checks++;
            if (in_bus.ready !== 1'b0 || occupancy !== 2'd2 || idx != 2) begin
               errors++;
               $display("FAIL bp_full: in_ready=%b occ=%0d accepted=%0d want 0,2,2",
                        in_bus.ready, occupancy, idx);
            end
         end
      end
      checks++;
      if (seen.size() != 3 || seen[0] !== src[0].data || seen[1] !== src[1].data ||
          seen[2] !== src[2].data) begin
         errors++;
         $display("FAIL bp_order: got %p want %h,%h,%h", seen, src[0].data, src[1].data, src[2].data);
      end
   endtask

   task automatic test_flush();
      ent_t e;
      ent_t d;
      out_bus.ready = 1'b0;
      in_bus.valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         e = rand_ent();
         in_bus.ctrl = e.ctrl;
         in_bus.data = e.data;
         tick();
      end
      d = rand_ent();
      d.ctrl[0] = 1'b1;
      in_bus.ctrl = d.ctrl;
      in_bus.data = d.data;
      flush = 1'b1;
      tick();
      flush        = 1'b0;
      in_bus.valid = 1'b0;
      checks++;
      if (out_bus.valid !== 1'b0 || out_bus.ctrl !== '0 || occupancy !== 2'd0 || out_bus.data !== '0) begin
         errors++;
         $display("FAIL flush_full: valid=%b ctrl=%h occ=%0d data=%h want all 0",
                  out_bus.valid, out_bus.ctrl, occupancy, out_bus.data);
      end
      out_bus.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_bus.valid === 1'b1 && out_bus.data === d.data) begin
            errors++;
            $display("FAIL flush_leak: flushed data %h reappeared", d.data);
         end
         tick();
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL flush_after%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_stall_cnt();
      ent_t e;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      e = rand_ent();
      out_bus.ready = 1'b0;
      in_bus.valid  = 1'b1;
      in_bus.ctrl   = e.ctrl;
      in_bus.data   = e.data;
      tick();
      in_bus.valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL stall_cycle%0d: dut=%h model=%h", i, dut_vec, model_vec());
         end
      end
      checks++;
      if (stall_cnt !== 4'd15) begin
         errors++;
         $display("FAIL stall_sat: got %0d want 15", stall_cnt);
      end
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checks++;
      if (stall_cnt !== 4'd0) begin
         errors++;
         $display("FAIL stall_clr: got %0d want 0", stall_cnt);
      end
      tick();
      checks++;
      if (stall_cnt !== 4'd1) begin
         errors++;
         $display("FAIL stall_resume: got %0d want 1", stall_cnt);
      end
      out_bus.ready = 1'b1;
      tick();
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL stall_drain: dut=%h model=%h", dut_vec, model_vec());
      end
   endtask

   task automatic test_random();
      ent_t e;
      for (int c = 0; c < 80; c++) begin
         e = rand_ent();
         // First phase keeps in_valid high to exercise accept+consume in ONE.
         in_bus.valid  = (c < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
         in_bus.ctrl   = e.ctrl;
         in_bus.data   = e.data;
         out_bus.ready = $urandom_range(0, 1);
         flush         = (c >= 8) && ($urandom_range(0, 19) == 0);
         cnt_clr       = ($urandom_range(0, 15) == 0);
         tick();
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL rand_cycle%0d: dut=%h model=%h", c, dut_vec, model_vec());
         end
         checks++;
         if (occupancy > 2'd2) begin
            errors++;
            $display("FAIL rand_occ%0d: got %0d want <=2", c, occupancy);
         end
      end
      flush   = 1'b0;
      cnt_clr = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      cnt_clr       = 1'b0;
      in_bus.valid  = 1'b0;
      in_bus.ctrl   = '0;
      in_bus.data   = '0;
      out_bus.ready = 1'b0;
      q.delete();
      cnt = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_stall_cnt();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
